// File: rtl/rr_arb_2x1_4_pkg.sv
// Shared constants and types for the round-robin 2:1 arbiter and its mux datapath.
// Select encodings match the mux: 0 passes source 0, 1 passes source 1.
package rr_arb_2x1_4_pkg;

  localparam int   DATA_W  = 4;
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  // A grant is only meaningful when vld is set; src names the winning source.
  typedef struct packed {
    logic vld;
    logic src;
  } grant_t;

endpackage

// File: rtl/rr_arb_2x1_4_mux.sv
// 4-bit 2:1 multiplexer used as the arbiter datapath.
// Purely combinational.
module mux_2x1_4
  import rr_arb_2x1_4_pkg::*;
(
  input  logic [DATA_W-1:0] in0_i,
  input  logic [DATA_W-1:0] in1_i,
  input  logic              sel_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = (sel_i == SEL_IN1) ? in1_i : in0_i;

endmodule

// File: rtl/rr_arb_2x1_4.sv
// Round-robin arbiter between two 4-bit valid/ready sources feeding a
// single-entry registered output stage, with saturating per-source beat counters.
module rr_arb_2x1_4
  import rr_arb_2x1_4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_src_q,   out_src_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              load_en;
  grant_t            gnt;
  logic              sel;
  logic [DATA_W-1:0] mux_y;

  assign load_en = !out_valid_q || out_ready;

  // Readys are held low while reset is asserted, even though the slot is empty.
  always_comb begin
    gnt = '0;
    if (rst_n && load_en) begin
      if (in0_valid && in1_valid) begin
        gnt.vld = 1'b1;
        gnt.src = ~last_grant_q;
      end else if (in0_valid) begin
        gnt.vld = 1'b1;
        gnt.src = SEL_IN0;
      end else if (in1_valid) begin
        gnt.vld = 1'b1;
        gnt.src = SEL_IN1;
      end
    end
  end

  assign sel       = gnt.vld ? gnt.src : last_grant_q;
  assign in0_ready = gnt.vld && (gnt.src == SEL_IN0);
  assign in1_ready = gnt.vld && (gnt.src == SEL_IN1);

  mux_2x1_4 u_mux (
    .in0_i (in0_data),
    .in1_i (in1_data),
    .sel_i (sel),
    .y_o   (mux_y)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (gnt.vld) begin
      out_valid_d  = 1'b1;
      out_data_d   = mux_y;
      out_src_d    = gnt.src;
      last_grant_d = gnt.src;
      if (gnt.src == SEL_IN0) cnt0_d = sat_inc(cnt0_q);
      else                    cnt1_d = sat_inc(cnt1_q);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so source 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_rr_arb_2x1_4.sv
// Directed bench for rr_arb_2x1_4: reset, contention, backpressure, drain,
// idle fairness, mid-run reset, and counter saturation on a CNT_W=2 instance.
module tb_rr_arb_2x1_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in0_data, in1_data;
  logic       in0_valid, in1_valid, out_ready;
  logic       in0_ready, in1_ready, out_valid, out_src;
  logic [3:0] out_data;
  logic [7:0] cnt0, cnt1;

  logic [3:0] s_in0_data, s_in1_data, s_out_data;
  logic       s_in0_valid, s_in1_valid, s_out_ready;
  logic       s_in0_ready, s_in1_ready, s_out_valid, s_out_src;
  logic [1:0] s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb_2x1_4 dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .cnt0(cnt0), .cnt1(cnt1)
  );

  rr_arb_2x1_4 #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in0_data(s_in0_data), .in0_valid(s_in0_valid), .in0_ready(s_in0_ready),
    .in1_data(s_in1_data), .in1_valid(s_in1_valid), .in1_ready(s_in1_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_src(s_out_src), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in0_data = 4'b0000; in1_data = 4'b1111;
    in0_valid = 1'b1;   in1_valid = 1'b1;
    out_ready = 1'b1;
    s_in0_data = 4'h0; s_in1_data = 4'h0;
    s_in0_valid = 1'b0; s_in1_valid = 1'b0; s_out_ready = 1'b1;

    // Reset held with both sources valid
    step(); step(); step();
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("rst_in1_ready", {7'd0, in1_ready}, 8'd0);
    chk("rst_cnt0", cnt0, 8'd0);
    chk("rst_cnt1", cnt1, 8'd0);
    chk("rst_out_data", {4'd0, out_data}, 8'd0);
    chk("rst_out_src", {7'd0, out_src}, 8'd0);

    // Release: first contention goes to in0, then strict alternation
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("cont_in0_ready", {7'd0, in0_ready}, (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("cont_in1_ready", {7'd0, in1_ready}, (i % 2 == 1) ? 8'd1 : 8'd0);
      step();
      chk("cont_out_data", {4'd0, out_data}, (i % 2 == 0) ? 8'h00 : 8'h0f);
      chk("cont_out_src", {7'd0, out_src}, (i % 2 == 0) ? 8'd0 : 8'd1);
      chk("cont_out_valid", {7'd0, out_valid}, 8'd1);
    end
    chk("cont_cnt0", cnt0, 8'd3);
    chk("cont_cnt1", cnt1, 8'd3);

    // Backpressure: slot full with 1111, downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in0_ready", {7'd0, in0_ready}, 8'd0);
      chk("bp_in1_ready", {7'd0, in1_ready}, 8'd0);
      step();
      chk("bp_out_data", {4'd0, out_data}, 8'h0f);
      chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
    end
    chk("bp_cnt0", cnt0, 8'd3);
    chk("bp_cnt1", cnt1, 8'd3);

    // Release stall: drain and refill in the same cycle
    out_ready = 1'b1;
    #1;
    chk("refill_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("refill_in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    chk("refill_out_valid", {7'd0, out_valid}, 8'd1);
    chk("refill_out_data", {4'd0, out_data}, 8'h00);
    chk("refill_out_src", {7'd0, out_src}, 8'd0);
    chk("refill_cnt0", cnt0, 8'd4);

    // Drain with nothing to refill
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("drain_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("drain_in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    chk("drain_out_valid", {7'd0, out_valid}, 8'd0);
    chk("drain_out_data", {4'd0, out_data}, 8'h00);
    chk("drain_out_src", {7'd0, out_src}, 8'd0);

    // in1 alone sends two beats, then both contend: in0 must win
    in1_valid = 1'b1; in1_data = 4'b0110;
    step();
    chk("solo1_out_data_a", {4'd0, out_data}, 8'h06);
    chk("solo1_out_src_a", {7'd0, out_src}, 8'd1);
    in1_data = 4'b0111;
    step();
    chk("solo1_out_data_b", {4'd0, out_data}, 8'h07);
    chk("solo1_cnt1", cnt1, 8'd5);
    in0_valid = 1'b1; in0_data = 4'b0011;
    #1;
    chk("fair_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("fair_in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    chk("fair_out_data", {4'd0, out_data}, 8'h03);
    chk("fair_out_src", {7'd0, out_src}, 8'd0);
    chk("fair_cnt0", cnt0, 8'd5);

    // Reset with a pending, stalled beat in the slot
    out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mrst_out_data", {4'd0, out_data}, 8'h00);
    chk("mrst_cnt0", cnt0, 8'd0);
    chk("mrst_cnt1", cnt1, 8'd0);
    step();
    rst_n = 1'b1;

    // Single source after reset
    in0_valid = 1'b1; in0_data = 4'b1010; out_ready = 1'b1;
    #1;
    chk("single_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("single_in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    chk("single_out_data", {4'd0, out_data}, 8'h0a);
    chk("single_out_src", {7'd0, out_src}, 8'd0);
    chk("single_out_valid", {7'd0, out_valid}, 8'd1);
    chk("single_cnt0", cnt0, 8'd1);
    chk("single_cnt1", cnt1, 8'd0);
    in0_valid = 1'b0;

    // Saturation on the 2-bit counter instance
    s_in0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in0_data = 4'(i + 5);
      step();
      chk("sat_out_data", {4'd0, s_out_data}, 8'(i + 5));
      chk("sat_out_valid", {7'd0, s_out_valid}, 8'd1);
      chk("sat_cnt0", {6'd0, s_cnt0}, (i + 1 > 3) ? 8'd3 : 8'(i + 1));
    end
    chk("sat_cnt1", {6'd0, s_cnt1}, 8'd0);
    s_in0_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
